// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;
  localparam int BE_W = 4;
  localparam logic [31:0] MMIO_ADDR_DEFAULT = 32'h0000_0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte-lane merge of new data into an old word under a byte-enable mask.
  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [BE_W-1:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// Single-port byte-enabled word RAM; rdata is registered and reads the pre-write contents.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic            clk,
  input  logic            we,
  input  logic [BE_W-1:0] be,
  input  logic [AW-1:0]   addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata
);
  logic [31:0] mem [DEPTH];
  logic        in_range;

  assign in_range = int'(addr) < DEPTH;

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= in_range ? mem[addr] : 32'h0;
  end
endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data responder: one outstanding request, WAIT_CYCLES wait states, one MMIO result register.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] MMIO_ADDR   = MMIO_ADDR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  input  logic [BE_W-1:0] req_be,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err,
  output logic            mmio_valid,
  output logic [31:0]     mmio_data
);
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW        = $clog2(WAIT_CYCLES + 2);
  localparam int WAIT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              lat_we;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_wdata;
  logic [BE_W-1:0]   lat_be;

  logic              accept, enter_resp;
  logic              cur_we, cur_err, cur_mmio;
  logic [31:0]       cur_addr, cur_wdata;
  logic [BE_W-1:0]   cur_be;
  logic              lat_err, lat_mmio;
  logic              ram_we;
  logic [31:0]       ram_rdata;

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) ||
           ((a != MMIO_ADDR) && ({2'b00, a[31:2]} >= 32'(DEPTH)));
  endfunction

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;

  // The RAM sees the live request in IDLE (zero-wait case) and the latched one afterwards.
  assign cur_we    = (state == ST_IDLE) ? req_we    : lat_we;
  assign cur_addr  = (state == ST_IDLE) ? req_addr  : lat_addr;
  assign cur_wdata = (state == ST_IDLE) ? req_wdata : lat_wdata;
  assign cur_be    = (state == ST_IDLE) ? req_be    : lat_be;
  assign cur_err   = addr_err(cur_addr);
  assign cur_mmio  = (cur_addr == MMIO_ADDR);

  assign enter_resp = ((state == ST_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                      ((state == ST_WAIT) && (cnt == '0));

  assign ram_we = reset && enter_resp && cur_we && !cur_err && !cur_mmio;

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (ram_we),
    .be    (cur_be),
    .addr  (cur_addr[AW+1:2]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      mmio_valid <= 1'b0;
      mmio_data  <= '0;
    end else begin
      mmio_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            cnt       <= CW'(WAIT_INIT);
            state     <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) state <= ST_RESP;
          else           cnt   <= cnt - 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (enter_resp && cur_we && !cur_err && cur_mmio) begin
        mmio_data  <= be_merge(mmio_data, cur_wdata, cur_be);
        mmio_valid <= 1'b1;
      end
    end
  end

  // Response fields derive only from registered state, so they hold steady while stalled.
  assign lat_err   = addr_err(lat_addr);
  assign lat_mmio  = (lat_addr == MMIO_ADDR);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_err   = rsp_valid && lat_err;
  assign rsp_rdata = (rsp_valid && !lat_we && !lat_err) ?
                     (lat_mmio ? mmio_data : ram_rdata) : 32'h0;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;
  localparam int          DEPTH = 64;
  localparam int          WAIT  = 1;
  localparam logic [31:0] MMIO  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mmio_valid;
  logic [31:0] mmio_data;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_model [DEPTH];
  logic [31:0] mmio_model;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT), .MMIO_ADDR(MMIO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mmio_valid (mmio_valid),
    .mmio_data  (mmio_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [7:0] lanes [4];
    for (int b = 0; b < 4; b++) lanes[b] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return {lanes[3], lanes[2], lanes[1], lanes[0]};
  endfunction

  // One full request/response; the model is updated before the DUT is driven.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int hold);
    logic [31:0] exp_rd;
    logic        exp_err, exp_pulse;
    int          lat, mcount;
    exp_err   = (addr % 4 != 0) || (addr != MMIO && addr / 4 >= DEPTH);
    exp_pulse = 1'b0;
    exp_rd    = 32'h0;
    if (!exp_err) begin
      if (we && addr == MMIO) begin
        mmio_model = merge_bytes(mmio_model, wdata, be);
        exp_pulse  = 1'b1;
      end else if (we) begin
        mem_model[addr / 4] = merge_bytes(mem_model[addr / 4], wdata, be);
      end else begin
        exp_rd = (addr == MMIO) ? mmio_model : mem_model[addr / 4];
      end
    end

    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);

    lat = 0; mcount = 0;
    do begin
      @(negedge clk);
      lat++;
      mcount += int'(mmio_valid);
    end while (!rsp_valid && lat < 20);
    check("latency", 32'(lat), 32'(WAIT + 1));
    if (!rsp_valid) return;

    for (int h = 0; h <= hold; h++) begin
      check("rsp_valid_held", 32'(rsp_valid), 32'd1);
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("rsp_err", 32'(rsp_err), 32'(exp_err));
      check("req_ready_busy", 32'(req_ready), 32'd0);
      if (h < hold) begin
        @(negedge clk);
        mcount += int'(mmio_valid);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    mcount += int'(mmio_valid);
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("req_ready_back", 32'(req_ready), 32'd1);
    check("mmio_pulses", 32'(mcount), 32'(exp_pulse));
    check("mmio_data", mmio_data, mmio_model);
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = '0; rsp_ready = 1'b0;
    mmio_model = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mmio_valid", 32'(mmio_valid), 32'd0);
    check("rst_mmio_data", mmio_data, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < DEPTH; i++) xact(1'b1, 32'(i * 4), $urandom, 4'hF, 0);

    xact(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 0);
    xact(1'b0, 32'h8, 32'h0, 4'h0, 0);
    xact(1'b1, 32'hC, 32'h11223344, 4'hF, 0);
    xact(1'b1, 32'hC, 32'hAABBCCDD, 4'b0101, 0);
    xact(1'b0, 32'hC, 32'h0, 4'h3, 0);
    check("partial_store_word", mem_model[3], 32'h11BB33DD);
    xact(1'b1, 32'h14, 32'h55555555, 4'b0000, 0);
    xact(1'b0, 32'h6, 32'h0, 4'hF, 1);
    xact(1'b0, 32'h400, 32'h0, 4'hF, 0);
    xact(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0);
    for (int i = 0; i < DEPTH; i++) xact(1'b0, 32'(i * 4), 32'h0, 4'($urandom), 0);
    xact(1'b1, MMIO, 32'd25, 4'hF, 0);
    xact(1'b0, MMIO, 32'h0, 4'hF, 0);
    xact(1'b0, 32'h8, 32'h0, 4'hF, 5);

    // Reset while a store to 0x10 sits in its wait state.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mmio_model = 32'h0;
    check("midrst_mmio_data", mmio_data, 32'h0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    xact(1'b0, 32'h10, 32'h0, 4'hF, 0);

    for (int n = 0; n < 200; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 6)       a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (kind == 6) a = 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'h1;
      else if (kind == 7) a = 32'($urandom_range(DEPTH, 1023) * 4);
      else                a = MMIO;
      xact(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words in data storage.
REQ-002 Parameter WAIT_CYCLES, default 1: wait states between accept and response; 0 is legal.
REQ-003 Parameter MMIO_ADDR, default 32'h0000_0100: byte address of the single memory-mapped result register.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 req_valid  input  1  MEM-stage request present.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address (ALU result from MEM stage).
REQ-010 req_wdata  input  32  store data.
REQ-011 req_be  input  4  byte enables; bit i gates byte i.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  pipeline consumes response.
REQ-014 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  access misaligned or out of range.
REQ-016 mmio_valid  output  1  one-cycle pulse on committed store to MMIO_ADDR.
REQ-017 mmio_data  output  32  value of that store, held until the next MMIO store.

Function
REQ-018 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 Accept = req_valid & req_ready; on accept, latch we/addr/wdata/be; go to WAIT with counter = WAIT_CYCLES-1, or directly to RESP if WAIT_CYCLES = 0.
REQ-020 WAIT: decrement counter each cycle; at counter 0 go to RESP on the next edge.
REQ-021 Load data capture, store commit and MMIO pulse SHALL occur on the edge entering RESP.
REQ-022 Latency: accept on edge N gives rsp_valid high from cycle N+1+WAIT_CYCLES.
REQ-023 RESP: rsp_valid held with rsp_rdata/rsp_err stable until rsp_valid & rsp_ready; then IDLE. No back-to-back accept in the handshake cycle.
REQ-024 Error if addr[1:0] != 0, or addr != MMIO_ADDR and addr[31:2] >= DEPTH.
REQ-025 Errored access: no storage write, no MMIO pulse, rsp_err = 1, rsp_rdata = 0.
REQ-026 Store: only bytes with req_be[i] = 1 are updated; be = 4'b0000 is a legal no-op store with rsp_err = 0.
REQ-027 Load ignores req_be and returns the full word.
REQ-028 A load from MMIO_ADDR returns the current mmio_data.
REQ-029 A load accepted after a store SHALL see that store's data; no forwarding bypass is needed because only one request is outstanding.
REQ-030 Request inputs are ignored outside IDLE.

Reset
REQ-031 On reset low at an edge: state = IDLE, counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, mmio_valid = 0, mmio_data = 0; req_ready = 1 after reset releases.
REQ-032 Reset mid-operation SHALL drop the pending request: no store commit, no response. Storage contents are not cleared.

Structure
REQ-033 Shared package dmem_pkg SHALL hold the state enum typedef, the default MMIO_ADDR constant and the byte-enable width.
REQ-034 Storage SHALL be a sub-module dmem_array: synchronous single-port byte-enabled word RAM, DEPTH words, with address, be, we, wdata and registered rdata.
REQ-035 FSM, wait counter, error check and MMIO register are in dmem_responder.

Verification
REQ-036 WAIT_CYCLES = 1: store 0xDEADBEEF to 0x8 with be = F, then load 0x8 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid 2 cycles after each accept.
REQ-037 Store 0x11223344 to 0xC with be = F, then store 0xAABBCCDD with be = 4'b0101, then load 0xC -> 0x11BB33DD.
REQ-038 Load 0x6 and load 0x400 with DEPTH = 64 -> rsp_err = 1, rsp_rdata = 0; a store to 0x400 leaves all words unchanged.
REQ-039 Store 25 to 0x100 -> mmio_valid high exactly one cycle, mmio_data = 25; a load of 0x100 returns 25.
REQ-040 Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stay stable and req_ready = 0; set rsp_ready = 1 -> IDLE next cycle.
REQ-041 Assert reset during WAIT of a store to 0x10 -> no response, word 0x10 unchanged, req_ready = 1 after reset is released.
